multicycle_control_unit: RTL and testbench

Parametrised multi-cycle successor to the single-cycle instruction decoder. It sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WRITEBACK using a state machine. It holds the instruction in an internal register, handshakes with instruction fetch and data memory, and issues per-phase control strobes to the datapath (ALU, register file, PC, data memory). It sits between the instruction memory port and the existing datapath.

---
 rtl/multicycle_control_unit.sv | 189 ++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// Multi-cycle control unit: sequences each instruction through
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK and issues per-phase datapath strobes.
// Optional feature macro: CU_PERF_EN (retired-instruction counter).
module multicycle_control_unit #(
   parameter int unsigned INSTR_W = 16,
   parameter int unsigned REG_AW  = 3,
   parameter int unsigned IMM_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 instr_valid,
   output logic                 instr_ready,
   input  logic [INSTR_W-1:0]   instruction,
   input  logic                 mem_ack,
   input  logic                 alu_zero,
   output logic [3:0]           alu_control,
   output logic                 alu_src,
   output logic                 reg_write_enable,
   output logic [REG_AW-1:0]    reg_write_addr,
   output logic                 mem_read,
   output logic                 mem_write,
   output logic                 mem_to_reg,
   output logic                 branch_taken,
   output logic                 jump,
   output logic [IMM_W-1:0]     immediate,
   output logic [INSTR_W-5:0]   jump_addr,
   output logic                 instr_retired,
   output logic [2:0]           state,
   output logic [31:0]          retired_count
);

   localparam int unsigned OP_W    = 4;
   localparam int unsigned JA_W    = INSTR_W - OP_W;
   localparam int unsigned RS1_LSB = INSTR_W - OP_W - REG_AW;
   localparam int unsigned RD_LSB  = INSTR_W - OP_W - 3 * REG_AW;
   localparam int unsigned SW_W    = IMM_W - 2;

   localparam logic [3:0] OP_ADDI = 4'h8;
   localparam logic [3:0] OP_ANDI = 4'h9;
   localparam logic [3:0] OP_ORI  = 4'hA;
   localparam logic [3:0] OP_LW   = 4'hB;
   localparam logic [3:0] OP_SW   = 4'hC;
   localparam logic [3:0] OP_BEQ  = 4'hD;
   localparam logic [3:0] OP_JMP  = 4'hE;
   localparam logic [3:0] OP_NOP  = 4'hF;

   localparam logic [3:0] ALU_ADD = 4'd0;
   localparam logic [3:0] ALU_SUB = 4'd1;
   localparam logic [3:0] ALU_AND = 4'd2;
   localparam logic [3:0] ALU_OR  = 4'd3;

   typedef enum logic [2:0] {
      S_FETCH     = 3'd0,
      S_DECODE    = 3'd1,
      S_EXECUTE   = 3'd2,
      S_MEM       = 3'd3,
      S_WRITEBACK = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [OP_W-1:0]   ir_op_q;
   logic [OP_W-1:0]   in_op;
   logic              accept;
   logic [IMM_W-1:0]  imm_d;
   logic [REG_AW-1:0] rwa_d;
   logic              op_itype;

   assign state    = state_q;
   assign in_op    = instruction[INSTR_W-1 -: OP_W];
   assign accept   = (state_q == S_FETCH) && instr_valid;
   assign op_itype = (ir_op_q == OP_ADDI) || (ir_op_q == OP_ANDI) || (ir_op_q == OP_ORI);

   // Decode operand fields straight from the fetched word so they are valid from DECODE on
   always_comb begin
      imm_d = '0;
      rwa_d = in_op[3] ? instruction[RS1_LSB +: REG_AW] : instruction[RD_LSB +: REG_AW];
      case (in_op)
         OP_ADDI, OP_ANDI, OP_ORI, OP_LW, OP_BEQ: imm_d = instruction[IMM_W-1:0];
         OP_SW: imm_d = {{2{instruction[SW_W-1]}}, instruction[SW_W-1:0]};
         default: imm_d = '0;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_FETCH;
      else        state_q <= state_d;
   end

   // Instruction register (only the opcode is needed after acceptance) and decoded fields
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir_op_q        <= '0;
         immediate      <= '0;
         jump_addr      <= '0;
         reg_write_addr <= '0;
      end else if (accept) begin
         ir_op_q        <= in_op;
         immediate      <= imm_d;
         jump_addr      <= instruction[JA_W-1:0];
         reg_write_addr <= rwa_d;
      end
   end

   // Next-state logic and per-phase strobes
   always_comb begin
      state_d          = state_q;
      instr_ready      = 1'b0;
      alu_control      = ALU_ADD;
      alu_src          = 1'b0;
      reg_write_enable = 1'b0;
      mem_read         = 1'b0;
      mem_write        = 1'b0;
      mem_to_reg       = 1'b0;
      branch_taken     = 1'b0;
      jump             = 1'b0;
      instr_retired    = 1'b0;
      case (state_q)
         S_FETCH: begin
            instr_ready = 1'b1;
            if (instr_valid) state_d = S_DECODE;
         end
         S_DECODE: begin
            if (ir_op_q == OP_JMP) begin
               jump          = 1'b1;
               instr_retired = 1'b1;
               state_d       = S_FETCH;
            end else if (ir_op_q == OP_NOP) begin
               instr_retired = 1'b1;
               state_d       = S_FETCH;
            end else begin
               state_d = S_EXECUTE;
            end
         end
         S_EXECUTE: begin
            alu_src = op_itype || (ir_op_q == OP_LW) || (ir_op_q == OP_SW);
            case (ir_op_q)
               OP_ANDI: alu_control = ALU_AND;
               OP_ORI:  alu_control = ALU_OR;
               OP_BEQ:  alu_control = ALU_SUB;
               default: alu_control = ir_op_q[3] ? ALU_ADD : {1'b0, ir_op_q[2:0]};
            endcase
            if ((ir_op_q == OP_LW) || (ir_op_q == OP_SW)) begin
               state_d = S_MEM;
            end else if (ir_op_q == OP_BEQ) begin
               branch_taken  = alu_zero;
               instr_retired = 1'b1;
               state_d       = S_FETCH;
            end else begin
               state_d = S_WRITEBACK;
            end
         end
         S_MEM: begin
            mem_read  = (ir_op_q == OP_LW);
            mem_write = (ir_op_q == OP_SW);
            if (mem_ack) begin
               if (ir_op_q == OP_LW) begin
                  state_d = S_WRITEBACK;
               end else begin
                  instr_retired = 1'b1;
                  state_d       = S_FETCH;
               end
            end
         end
         S_WRITEBACK: begin
            reg_write_enable = 1'b1;
            mem_to_reg       = (ir_op_q == OP_LW);
            instr_retired    = 1'b1;
            state_d          = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

`ifdef CU_PERF_EN
   logic [31:0] retired_cnt_q;

   // Free-running retired-instruction counter, wraps naturally
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)             retired_cnt_q <= '0;
      else if (instr_retired) retired_cnt_q <= retired_cnt_q + 32'd1;
   end

   assign retired_count = retired_cnt_q;
`else
   assign retired_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-instruction vector table
// plus hand-written reset and mid-MEM reset sequences.
module tb_multicycle_control_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instruction;
   logic        mem_ack;
   logic        alu_zero;
   logic [3:0]  alu_control;
   logic        alu_src;
   logic        reg_write_enable;
   logic [2:0]  reg_write_addr;
   logic        mem_read;
   logic        mem_write;
   logic        mem_to_reg;
   logic        branch_taken;
   logic        jump;
   logic [7:0]  immediate;
   logic [11:0] jump_addr;
   logic        instr_retired;
   logic [2:0]  state;
   logic [31:0] retired_count;

   int compared   = 0;
   int mismatched = 0;

   multicycle_control_unit dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instruction(instruction), .mem_ack(mem_ack), .alu_zero(alu_zero),
      .alu_control(alu_control), .alu_src(alu_src), .reg_write_enable(reg_write_enable),
      .reg_write_addr(reg_write_addr), .mem_read(mem_read), .mem_write(mem_write),
      .mem_to_reg(mem_to_reg), .branch_taken(branch_taken), .jump(jump),
      .immediate(immediate), .jump_addr(jump_addr), .instr_retired(instr_retired),
      .state(state), .retired_count(retired_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] instr;
      int          nack;
      logic        zero;
      logic [29:0] trace;
      int          lat;
      int          rwe_n;
      logic [2:0]  rwa;
      logic [3:0]  alu;
      logic        src;
      logic        chk_imm;
      logic [7:0]  imm;
      int          m2r_n;
      int          br_n;
      int          jmp_n;
      int          rd_n;
      int          wr_n;
      logic        chk_ja;
      logic [11:0] ja;
   } vec_t;

   localparam int NV = 14;
   vec_t vecs [NV];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int k);
      vec_t        v;
      logic [29:0] trace;
      int          cyc, rwe_n, rd_n, wr_n, jmp_n, m2r_n, br_n, memcnt;
      logic [3:0]  alu_c;
      logic        src_c;
      logic [2:0]  rwa_c;
      logic [7:0]  imm_c;
      logic [11:0] ja_c;
      bit          done;
      v = vecs[k];
      trace = '0; cyc = 0; rwe_n = 0; rd_n = 0; wr_n = 0; jmp_n = 0; m2r_n = 0;
      br_n = 0; memcnt = 0; alu_c = '0; src_c = 1'b0; rwa_c = '0; imm_c = '0;
      ja_c = '0; done = 1'b0;
      instruction = v.instr;
      instr_valid = 1'b1;
      alu_zero    = v.zero;
      mem_ack     = 1'b1;
      #1;
      check($sformatf("v%0d ready_in_fetch", k), 32'(instr_ready), 32'd1);
      @(posedge clk);
      for (int c = 1; c <= 20 && !done; c++) begin
         @(negedge clk);
         if (state == 3'd3) begin
            memcnt++;
            mem_ack = (memcnt == v.nack);
         end else begin
            mem_ack = 1'b1;
         end
         #1;
         trace = {trace[26:0], state};
         if (mem_read)         rd_n++;
         if (mem_write)        wr_n++;
         if (jump)             jmp_n++;
         if (mem_to_reg)       m2r_n++;
         if (branch_taken)     br_n++;
         if (state == 3'd2) begin
            alu_c = alu_control;
            src_c = alu_src;
         end
         if (reg_write_enable) begin
            rwe_n++;
            rwa_c = reg_write_addr;
         end
         if (instr_retired) begin
            done  = 1'b1;
            cyc   = c;
            imm_c = immediate;
            ja_c  = jump_addr;
         end
      end
      if (!done) check($sformatf("v%0d retire_timeout", k), 32'd0, 32'd1);
      check($sformatf("v%0d state_trace", k), 32'(trace), 32'(v.trace));
      check($sformatf("v%0d latency", k), 32'(cyc + 1), 32'(v.lat));
      check($sformatf("v%0d rwe_cycles", k), 32'(rwe_n), 32'(v.rwe_n));
      if (v.rwe_n > 0) check($sformatf("v%0d rw_addr", k), 32'(rwa_c), 32'(v.rwa));
      check($sformatf("v%0d alu_control", k), 32'(alu_c), 32'(v.alu));
      check($sformatf("v%0d alu_src", k), 32'(src_c), 32'(v.src));
      if (v.chk_imm) check($sformatf("v%0d immediate", k), 32'(imm_c), 32'(v.imm));
      check($sformatf("v%0d mem_to_reg_cycles", k), 32'(m2r_n), 32'(v.m2r_n));
      check($sformatf("v%0d branch_cycles", k), 32'(br_n), 32'(v.br_n));
      check($sformatf("v%0d jump_cycles", k), 32'(jmp_n), 32'(v.jmp_n));
      check($sformatf("v%0d mem_read_cycles", k), 32'(rd_n), 32'(v.rd_n));
      check($sformatf("v%0d mem_write_cycles", k), 32'(wr_n), 32'(v.wr_n));
      if (v.chk_ja) check($sformatf("v%0d jump_addr", k), 32'(ja_c), 32'(v.ja));
      @(negedge clk);
      #1;
      check($sformatf("v%0d back_in_fetch", k), 32'(state), 32'd0);
   endtask

   initial begin
      bit reached;
      //           instr     nack z  trace        lat rwe rwa alu src ci imm   m2r br jmp rd wr cj ja
      vecs[0]  = '{16'h0298, 0, 1'b0, 30'o124,    4, 1, 3'd3, 4'd0, 1'b0, 1'b0, 8'h00, 0, 0, 0, 0, 0, 1'b0, 12'h000};
      vecs[1]  = '{16'h1DE8, 0, 1'b0, 30'o124,    4, 1, 3'd5, 4'd1, 1'b0, 1'b0, 8'h00, 0, 0, 0, 0, 0, 1'b0, 12'h000};
      vecs[2]  = '{16'h7010, 0, 1'b0, 30'o124,    4, 1, 3'd2, 4'd7, 1'b0, 1'b0, 8'h00, 0, 0, 0, 0, 0, 1'b0, 12'h000};
      vecs[3]  = '{16'h8A7F, 0, 1'b0, 30'o124,    4, 1, 3'd5, 4'd0, 1'b1, 1'b1, 8'h7F, 0, 0, 0, 0, 0, 1'b0, 12'h000};
      vecs[4]  = '{16'h9380, 0, 1'b0, 30'o124,    4, 1, 3'd1, 4'd2, 1'b1, 1'b1, 8'h80, 0, 0, 0, 0, 0, 1'b0, 12'h000};
      vecs[5]  = '{16'hAE01, 0, 1'b0, 30'o124,    4, 1, 3'd7, 4'd3, 1'b1, 1'b1, 8'h01, 0, 0, 0, 0, 0, 1'b0, 12'h000};
      vecs[6]  = '{16'hB205, 3, 1'b0, 30'o123334, 7, 1, 3'd1, 4'd0, 1'b1, 1'b1, 8'h05, 1, 0, 0, 3, 0, 1'b0, 12'h000};
      vecs[7]  = '{16'hB205, 1, 1'b0, 30'o1234,   5, 1, 3'd1, 4'd0, 1'b1, 1'b1, 8'h05, 1, 0, 0, 1, 0, 1'b0, 12'h000};
      vecs[8]  = '{16'hC03F, 2, 1'b0, 30'o1233,   5, 0, 3'd0, 4'd0, 1'b1, 1'b1, 8'hFF, 0, 0, 0, 0, 2, 1'b0, 12'h000};
      vecs[9]  = '{16'hC020, 1, 1'b0, 30'o123,    4, 0, 3'd0, 4'd0, 1'b1, 1'b1, 8'hE0, 0, 0, 0, 0, 1, 1'b0, 12'h000};
      vecs[10] = '{16'hD004, 0, 1'b1, 30'o12,     3, 0, 3'd0, 4'd1, 1'b0, 1'b1, 8'h04, 0, 1, 0, 0, 0, 1'b0, 12'h000};
      vecs[11] = '{16'hD004, 0, 1'b0, 30'o12,     3, 0, 3'd0, 4'd1, 1'b0, 1'b1, 8'h04, 0, 0, 0, 0, 0, 1'b0, 12'h000};
      vecs[12] = '{16'hE123, 0, 1'b0, 30'o1,      2, 0, 3'd0, 4'd0, 1'b0, 1'b0, 8'h00, 0, 0, 1, 0, 0, 1'b1, 12'h123};
      vecs[13] = '{16'hF000, 0, 1'b0, 30'o1,      2, 0, 3'd0, 4'd0, 1'b0, 1'b0, 8'h00, 0, 0, 0, 0, 0, 1'b0, 12'h000};

      // Reset state
      rst_n = 1'b0; instr_valid = 1'b0; instruction = 16'h0000; mem_ack = 1'b0; alu_zero = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("rst state", 32'(state), 32'd0);
      check("rst instr_ready", 32'(instr_ready), 32'd1);
      check("rst strobes", 32'({jump, branch_taken, mem_read, mem_write, reg_write_enable,
                                mem_to_reg, instr_retired, alu_src}), 32'd0);
      check("rst alu_control", 32'(alu_control), 32'd0);
      check("rst immediate", 32'(immediate), 32'd0);
      check("rst jump_addr", 32'(jump_addr), 32'd0);
      check("rst reg_write_addr", 32'(reg_write_addr), 32'd0);
      check("rst retired_count", retired_count, 32'd0);
      rst_n = 1'b1;

      // Idle FETCH without instr_valid stays put
      repeat (2) @(negedge clk);
      #1;
      check("idle state", 32'(state), 32'd0);

      // Back-to-back table vectors, instr_valid held high throughout
      for (int k = 0; k < NV; k++) run_vec(k);

`ifdef CU_PERF_EN
      check("retired_count", retired_count, 32'(NV));
`else
      check("retired_count", retired_count, 32'd0);
`endif

      // Reset asserted during MEM of an LW
      instruction = 16'hB205; instr_valid = 1'b1; mem_ack = 1'b0;
      @(posedge clk);
      #1;
      instr_valid = 1'b0;
      reached = 1'b0;
      for (int c = 0; c < 10 && !reached; c++) begin
         @(negedge clk);
         if (state == 3'd3) reached = 1'b1;
      end
      if (!reached) check("midrst reach_mem_timeout", 32'd0, 32'd1);
      @(negedge clk);
      #1;
      check("midrst mem_read_before", 32'(mem_read), 32'd1);
      rst_n = 1'b0;
      #1;
      check("midrst mem_read_dropped", 32'(mem_read), 32'd0);
      check("midrst state", 32'(state), 32'd0);
      check("midrst reg_write_addr", 32'(reg_write_addr), 32'd0);
      check("midrst retired_count", retired_count, 32'd0);
      mem_ack = 1'b1;
      @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         #1;
         check($sformatf("postrst c%0d rwe", c), 32'(reg_write_enable), 32'd0);
         check($sformatf("postrst c%0d state", c), 32'(state), 32'd0);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
